// File: rtl/control_unit_pipe.sv
// control_unit_pipe: decode-stage control unit with registered ID/EX bundle,
// stall/flush/bubble handling and a HALT drain FSM.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_Instruction[NB]      opcode field instr[31:26]
//   i_Special[NB]          funct field instr[5:0]
//   i_Valid                IF/ID holds a real instruction
//   i_Stall                hold the ID/EX control register
//   i_Flush                load a bubble into the ID/EX control register
//   o_ALUSrc .. o_Jump     ID/EX control bundle feeding EX/MEM/WB
//   o_Valid                bundle is a real instruction
//   o_IllegalOp            one slot per illegal opcode
//   o_Halted               sticky, set once the HALT drain completes
//
// Optional feature: define CTRL_LUI_EN to decode opcode 001111 as LUI.
module control_unit_pipe #(
   parameter int NB           = 6,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic [NB-1:0] i_Instruction,
   input  logic [NB-1:0] i_Special,
   input  logic          i_Valid,
   input  logic          i_Stall,
   input  logic          i_Flush,
   output logic          o_ALUSrc,
   output logic [1:0]    o_ExtensionMode,
   output logic          o_RegDst,
   output logic          o_RegWrite,
   output logic          o_MemRead,
   output logic          o_MemWrite,
   output logic          o_MemToReg,
   output logic [1:0]    o_Branch,
   output logic [1:0]    o_Jump,
   output logic          o_Valid,
   output logic          o_IllegalOp,
   output logic          o_Halted
);

   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   localparam logic [NB-1:0] OP_RTYPE = NB'(6'b000000);
   localparam logic [NB-1:0] OP_ADDI  = NB'(6'b001000);
   localparam logic [NB-1:0] OP_SLTI  = NB'(6'b001010);
   localparam logic [NB-1:0] OP_ANDI  = NB'(6'b001100);
   localparam logic [NB-1:0] OP_ORI   = NB'(6'b001101);
   localparam logic [NB-1:0] OP_XORI  = NB'(6'b001110);
   localparam logic [NB-1:0] OP_LW    = NB'(6'b100011);
   localparam logic [NB-1:0] OP_SW    = NB'(6'b101011);
   localparam logic [NB-1:0] OP_BEQ   = NB'(6'b000100);
   localparam logic [NB-1:0] OP_BNE   = NB'(6'b000101);
   localparam logic [NB-1:0] OP_J     = NB'(6'b000010);
   localparam logic [NB-1:0] OP_HALT  = NB'(6'b111111);
`ifdef CTRL_LUI_EN
   localparam logic [NB-1:0] OP_LUI   = NB'(6'b001111);
`endif
   localparam logic [NB-1:0] FN_JR    = NB'(6'b001000);

   typedef struct packed {
      logic       alu_src;
      logic [1:0] ext_mode;
      logic       reg_dst;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic [1:0] branch;
      logic [1:0] jump;
      logic       valid;
      logic       illegal;
   } ctrl_t;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_HALTED
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          halted_q;
   ctrl_t         ctrl_q;
   ctrl_t         ctrl_d;
   logic          halt_trig;

   // Combinational decode; anything outside RUN decodes to a bubble.
   always_comb begin
      ctrl_d    = '0;
      halt_trig = 1'b0;
      if (state_q == ST_RUN && i_Valid) begin
         unique case (i_Instruction)
            OP_RTYPE: begin
               ctrl_d.reg_dst   = 1'b1;
               ctrl_d.valid     = 1'b1;
               if (i_Special == FN_JR) begin
                  ctrl_d.jump = 2'b10;
               end else begin
                  ctrl_d.reg_write = 1'b1;
               end
            end
            OP_ADDI, OP_SLTI: begin
               ctrl_d.alu_src   = 1'b1;
               ctrl_d.reg_write = 1'b1;
               ctrl_d.valid     = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
               ctrl_d.alu_src   = 1'b1;
               ctrl_d.ext_mode  = 2'b01;
               ctrl_d.reg_write = 1'b1;
               ctrl_d.valid     = 1'b1;
            end
            OP_LW: begin
               ctrl_d.alu_src    = 1'b1;
               ctrl_d.reg_write  = 1'b1;
               ctrl_d.mem_read   = 1'b1;
               ctrl_d.mem_to_reg = 1'b1;
               ctrl_d.valid      = 1'b1;
            end
            OP_SW: begin
               ctrl_d.alu_src   = 1'b1;
               ctrl_d.mem_write = 1'b1;
               ctrl_d.valid     = 1'b1;
            end
            OP_BEQ: begin
               ctrl_d.branch = 2'b01;
               ctrl_d.valid  = 1'b1;
            end
            OP_BNE: begin
               ctrl_d.branch = 2'b10;
               ctrl_d.valid  = 1'b1;
            end
            OP_J: begin
               ctrl_d.jump  = 2'b01;
               ctrl_d.valid = 1'b1;
            end
`ifdef CTRL_LUI_EN
            OP_LUI: begin
               ctrl_d.alu_src   = 1'b1;
               ctrl_d.ext_mode  = 2'b10;
               ctrl_d.reg_write = 1'b1;
               ctrl_d.valid     = 1'b1;
            end
`endif
            // HALT itself issues as a bubble
            OP_HALT: halt_trig = 1'b1;
            default: ctrl_d.illegal = 1'b1;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ctrl_q   <= '0;
         state_q  <= ST_RUN;
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         if (i_Flush) begin
            ctrl_q <= '0;
         end else if (!i_Stall) begin
            ctrl_q <= ctrl_d;
         end
         unique case (state_q)
            ST_RUN: begin
               // HALT only takes effect once it is actually loaded
               if (halt_trig && !i_Flush && !i_Stall) begin
                  state_q <= ST_DRAIN;
                  cnt_q   <= CW'(DRAIN_CYCLES - 1);
               end
            end
            ST_DRAIN: begin
               if (!i_Stall) begin
                  if (cnt_q == '0) begin
                     state_q  <= ST_HALTED;
                     halted_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            ST_HALTED: halted_q <= 1'b1;
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign o_ALUSrc        = ctrl_q.alu_src;
   assign o_ExtensionMode = ctrl_q.ext_mode;
   assign o_RegDst        = ctrl_q.reg_dst;
   assign o_RegWrite      = ctrl_q.reg_write;
   assign o_MemRead       = ctrl_q.mem_read;
   assign o_MemWrite      = ctrl_q.mem_write;
   assign o_MemToReg      = ctrl_q.mem_to_reg;
   assign o_Branch        = ctrl_q.branch;
   assign o_Jump          = ctrl_q.jump;
   assign o_Valid         = ctrl_q.valid;
   assign o_IllegalOp     = ctrl_q.illegal;
   assign o_Halted        = halted_q;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed testbench for control_unit_pipe.
// Bundle order: ALUSrc,Ext[2],RegDst,RegWrite,MemRd,MemWr,MemToReg,Br[2],J[2],Valid,Ill
module tb_control_unit_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic [5:0] fn;
   logic       vld;
   logic       stall;
   logic       flush;
   logic       alusrc, regdst, regwr, memrd, memwr, memtoreg;
   logic       ovalid, illegal, halted;
   logic [1:0] ext, br, jmp;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   control_unit_pipe #(.NB(6), .DRAIN_CYCLES(4)) dut (
      .i_clk(clk),
      .i_reset(rst),
      .i_Instruction(op),
      .i_Special(fn),
      .i_Valid(vld),
      .i_Stall(stall),
      .i_Flush(flush),
      .o_ALUSrc(alusrc),
      .o_ExtensionMode(ext),
      .o_RegDst(regdst),
      .o_RegWrite(regwr),
      .o_MemRead(memrd),
      .o_MemWrite(memwr),
      .o_MemToReg(memtoreg),
      .o_Branch(br),
      .o_Jump(jmp),
      .o_Valid(ovalid),
      .o_IllegalOp(illegal),
      .o_Halted(halted)
   );

   wire [13:0] bundle = {alusrc, ext, regdst, regwr, memrd, memwr,
                         memtoreg, br, jmp, ovalid, illegal};

   localparam logic [13:0] E_BUB  = 14'b0;
   localparam logic [13:0] E_ADDI = {1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [13:0] E_ORI  = {1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [13:0] E_LW   = {1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [13:0] E_SW   = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [13:0] E_BNE  = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0};
   localparam logic [13:0] E_R    = {1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [13:0] E_JR   = {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0};
   localparam logic [13:0] E_J    = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0};
   localparam logic [13:0] E_ILL  = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
   localparam logic [13:0] E_LUI  = {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};

   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] ORI  = 6'b001101;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;
   localparam logic [5:0] J    = 6'b000010;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] HALT = 6'b111111;
   localparam logic [5:0] LUI  = 6'b001111;

   task automatic step(input logic r, input logic [5:0] o,
                       input logic [5:0] f, input logic v,
                       input logic s, input logic fl);
      @(negedge clk);
      rst   = r;
      op    = o;
      fn    = f;
      vld   = v;
      stall = s;
      flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b(input string tag, input logic [13:0] exp);
      total++;
      assert (bundle === exp) else begin
         bad++;
         $error("FAIL %s bundle obs=%b exp=%b", tag, bundle, exp);
      end
   endtask

   task automatic chk_h(input string tag, input logic exp);
      total++;
      assert (halted === exp) else begin
         bad++;
         $error("FAIL %s halted obs=%b exp=%b", tag, halted, exp);
      end
   endtask

   initial begin
      rst = 1'b1; op = '0; fn = '0; vld = 1'b0; stall = 1'b0; flush = 1'b0;

      step(1, ADDI, 0, 1, 0, 0);
      step(1, ADDI, 0, 1, 0, 0);
      chk_b("reset", E_BUB);
      chk_h("reset", 1'b0);

      step(0, ADDI, 0, 1, 0, 0); chk_b("addi", E_ADDI);
      step(0, ORI,  0, 1, 0, 0); chk_b("ori", E_ORI);

      step(0, LW, 0, 1, 0, 0); chk_b("lw", E_LW);
      step(0, SW, 0, 1, 1, 0); chk_b("stall1", E_LW);
      step(0, SW, 0, 1, 1, 0); chk_b("stall2", E_LW);
      step(0, SW, 0, 1, 0, 0); chk_b("sw", E_SW);

      step(0, BEQ, 0, 1, 0, 1); chk_b("beq_flush", E_BUB);
      step(0, BNE, 0, 1, 0, 0); chk_b("bne", E_BNE);
      step(0, RT, 6'b100000, 1, 0, 0); chk_b("rtype", E_R);
      step(0, RT, 6'b001000, 1, 0, 0); chk_b("jr", E_JR);
      step(0, J, 0, 1, 0, 0); chk_b("j", E_J);
      step(0, ADDI, 0, 0, 0, 0); chk_b("novalid", E_BUB);

      step(0, 6'b110011, 0, 1, 0, 0); chk_b("illegal", E_ILL);
      step(0, ADDI, 0, 1, 0, 0); chk_b("ill_once", E_ADDI);

      step(0, LUI, 0, 1, 0, 0);
`ifdef CTRL_LUI_EN
      chk_b("lui", E_LUI);
`else
      chk_b("lui", E_ILL);
`endif

      // flushed or stalled HALT must not start the drain
      step(0, HALT, 0, 1, 0, 1); chk_b("halt_flush", E_BUB);
      step(0, ADDI, 0, 1, 0, 0); chk_b("after_hflush", E_ADDI);
      step(0, HALT, 0, 1, 1, 0); chk_b("halt_stall", E_ADDI);
      step(0, ADDI, 0, 1, 0, 0); chk_b("after_hstall", E_ADDI);
      chk_h("after_hstall", 1'b0);

      // plain drain: halted after 4th edge following the HALT load
      step(0, HALT, 0, 1, 0, 0); chk_b("halt", E_BUB); chk_h("halt_e0", 1'b0);
      step(0, ADDI, 0, 1, 0, 0); chk_b("drain1", E_BUB); chk_h("drain1", 1'b0);
      step(0, ADDI, 0, 1, 0, 0); chk_b("drain2", E_BUB); chk_h("drain2", 1'b0);
      step(0, ADDI, 0, 1, 0, 0); chk_b("drain3", E_BUB); chk_h("drain3", 1'b0);
      step(0, ADDI, 0, 1, 0, 0); chk_b("drain4", E_BUB); chk_h("drain4", 1'b1);
      step(0, ADDI, 0, 1, 0, 1); chk_b("halted_flush", E_BUB);
      chk_h("halted_flush", 1'b1);
      step(0, ADDI, 0, 1, 0, 0); chk_b("halted", E_BUB); chk_h("halted", 1'b1);

      step(1, ADDI, 0, 1, 0, 0); chk_h("reset2", 1'b0); chk_b("reset2", E_BUB);
      step(0, ADDI, 0, 1, 0, 0); chk_b("run_again", E_ADDI);

      // drain with one stall cycle: halted after 5th edge
      step(0, HALT, 0, 1, 0, 0); chk_h("sd0", 1'b0);
      step(0, ADDI, 0, 1, 0, 0); chk_h("sd1", 1'b0);
      step(0, ADDI, 0, 1, 1, 0); chk_h("sd2", 1'b0); chk_b("sd2", E_BUB);
      step(0, ADDI, 0, 1, 0, 0); chk_h("sd3", 1'b0);
      step(0, ADDI, 0, 1, 0, 0); chk_h("sd4", 1'b0);
      step(0, ADDI, 0, 1, 0, 0); chk_h("sd5", 1'b1); chk_b("sd5", E_BUB);

      // reset in the middle of a drain returns to RUN
      step(1, ADDI, 0, 1, 0, 0);
      step(0, HALT, 0, 1, 0, 0);
      step(0, ADDI, 0, 1, 0, 0);
      step(1, ADDI, 0, 1, 0, 0); chk_h("mid_rst", 1'b0);
      step(0, ADDI, 0, 1, 0, 0); chk_b("mid_rst_run", E_ADDI);
      step(0, ADDI, 0, 1, 0, 0);
      step(0, ADDI, 0, 1, 0, 0);
      step(0, ADDI, 0, 1, 0, 0); chk_h("mid_rst_nohalt", 1'b0);
      chk_b("mid_rst_run2", E_ADDI);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
